// File: rtl/cam_cmd_pkg.sv
// rtl/cam_cmd_pkg.sv - shared opcodes, word/status field positions and FSM encoding for the HPS command path
package cam_cmd_pkg;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_CAP_START  = 3'd1;
    localparam logic [2:0] OP_CAP_STOP   = 3'd2;
    localparam logic [2:0] OP_SET_THRESH = 3'd3;
    localparam logic [2:0] OP_SET_MODE   = 3'd4;
    localparam logic [2:0] OP_CLEAR      = 3'd5;

    // HPS->FPGA word: [15] seq toggle, [14:12] opcode, [11:0] argument
    localparam int SEQ_BIT = 15;
    localparam int OP_MSB  = 14;
    localparam int OP_LSB  = 12;
    localparam int ARG_MSB = 11;
    localparam int ARG_LSB = 0;

    localparam int ST_ACK     = 15;
    localparam int ST_OP_MSB  = 14;
    localparam int ST_OP_LSB  = 12;
    localparam int ST_BUSY    = 11;
    localparam int ST_ERR     = 10;
    localparam int ST_TIMEOUT = 9;
    localparam int ST_RSVD    = 8;
    localparam int ST_CNT_MSB = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/hps_cmd_watchdog.sv
// rtl/hps_cmd_watchdog.sv - cycle counter that flags a capture command left unaccepted for LIMIT cycles
module hps_cmd_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    // Counts cycles spent waiting; the count restarts for every new wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = run && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/hps_cmd_decoder.sv
// rtl/hps_cmd_decoder.sv - decodes HPS PIO command words into config writes and handshaked capture commands
// Optional ISSUE timeout enabled by defining HPS_CMD_TIMEOUT_EN.
module hps_cmd_decoder
    import cam_cmd_pkg::*;
#(
    parameter int ARG_W          = 12,
    parameter int CNT_W          = 8,
    parameter int THRESH_RST     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      pio_in,
    output logic             cmd_valid,
    output logic [2:0]       cmd_op,
    output logic [ARG_W-1:0] cmd_arg,
    input  logic             cmd_ready,
    output logic [ARG_W-1:0] thresh_out,
    output logic [3:0]       mode_out,
    output logic [15:0]      status
);

    state_t             state;
    logic               busy;
    logic               seq;
    logic [2:0]         op;
    logic [ARG_W-1:0]   arg;
    logic               valid_q;
    logic [ARG_W-1:0]   thresh_q;
    logic [3:0]         mode_q;
    logic               ack_toggle;
    logic [2:0]         last_op;
    logic               err_flag;
    logic               timeout_flag;
    logic [CNT_W-1:0]   done_cnt;
    logic               expired;

`ifdef HPS_CMD_TIMEOUT_EN
    hps_cmd_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state == S_ISSUE),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            seq          <= 1'b0;
            op           <= OP_NOP;
            arg          <= '0;
            valid_q      <= 1'b0;
            thresh_q     <= ARG_W'(THRESH_RST);
            mode_q       <= 4'd0;
            ack_toggle   <= 1'b0;
            last_op      <= OP_NOP;
            err_flag     <= 1'b0;
            timeout_flag <= 1'b0;
            done_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Compare with the acknowledged toggle so words written while busy coalesce.
                    if (pio_in[SEQ_BIT] != ack_toggle) begin
                        seq   <= pio_in[SEQ_BIT];
                        op    <= pio_in[OP_MSB:OP_LSB];
                        arg   <= pio_in[ARG_MSB:ARG_LSB];
                        state <= S_DECODE;
                        busy  <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state <= S_DONE;
                    case (op)
                        OP_NOP: begin
                        end
                        OP_CAP_START, OP_CAP_STOP: begin
                            valid_q <= 1'b1;
                            state   <= S_ISSUE;
                        end
                        OP_SET_THRESH: thresh_q <= arg;
                        OP_SET_MODE:   mode_q   <= arg[3:0];
                        OP_CLEAR: begin
                            err_flag     <= 1'b0;
                            timeout_flag <= 1'b0;
                            done_cnt     <= '0;
                        end
                        default:       err_flag <= 1'b1;
                    endcase
                end
                S_ISSUE: begin
                    // A handshake on the limit cycle takes priority over the timeout.
                    if (valid_q && cmd_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_DONE;
                    end else if (expired) begin
                        valid_q      <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack_toggle <= seq;
                    last_op    <= op;
                    if (op != OP_CLEAR) begin
                        done_cnt <= done_cnt + CNT_W'(1);
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid  = valid_q;
    assign cmd_op     = op;
    assign cmd_arg    = arg;
    assign thresh_out = thresh_q;
    assign mode_out   = mode_q;

    assign status[ST_ACK]               = ack_toggle;
    assign status[ST_OP_MSB:ST_OP_LSB]  = last_op;
    assign status[ST_BUSY]              = busy;
    assign status[ST_ERR]               = err_flag;
    assign status[ST_TIMEOUT]           = timeout_flag;
    assign status[ST_RSVD]              = 1'b0;
    assign status[ST_CNT_MSB:0]         = 8'(done_cnt);

endmodule
